// File: rtl/batalha_pkg.sv
// Shared types and constants for the battleship placement path: FSM states,
// ship type codes and the fixed fleet order walked by the placement sequencer.
package batalha_pkg;

  localparam int COORD_W    = 4;
  localparam int TIPO_W     = 3;
  localparam int ORI_W      = 3;
  localparam int IDX_W      = 3;
  localparam int MAX_NAVIOS = 8;

  typedef enum logic [2:0] {
    OCIOSO      = 3'd0,
    ENTRADA     = 3'd1,
    VALIDA      = 3'd2,
    LIBERA_OK   = 3'd3,
    LIBERA_ERRO = 3'd4,
    CONCLUIDO   = 3'd5
  } estado_t;

  typedef logic [TIPO_W-1:0] tipo_t;

  localparam tipo_t TIPO_PORTA_AVIOES = 3'd0;
  localparam tipo_t TIPO_ENCOURACADO  = 3'd1;
  localparam tipo_t TIPO_CRUZADOR     = 3'd2;
  localparam tipo_t TIPO_SUBMARINO    = 3'd3;
  localparam tipo_t TIPO_DESTROIER    = 3'd4;

  // Index 0 is the rightmost entry; slots past the standard five only matter
  // for fleets configured larger than the classic one.
  localparam logic [MAX_NAVIOS-1:0][TIPO_W-1:0] FROTA = {
    TIPO_DESTROIER, TIPO_SUBMARINO, TIPO_DESTROIER,
    TIPO_DESTROIER, TIPO_SUBMARINO, TIPO_CRUZADOR,
    TIPO_ENCOURACADO, TIPO_PORTA_AVIOES
  };

  function automatic tipo_t tipo_do_navio(input logic [IDX_W-1:0] idx);
    return FROTA[idx];
  endfunction

endpackage

// File: rtl/sequenciador_posicionamento_if.sv
// Handshake bundle between the placement sequencer (slave), the player entry
// source and the Validador; the environment side uses the master modport.
interface sequenciador_posicionamento_if;
  import batalha_pkg::*;

  logic               start;
  logic               confirma;
  logic [COORD_W-1:0] x_in;
  logic [COORD_W-1:0] y_in;
  logic               direcao_in;
  logic [ORI_W-1:0]   orientacao_in;
  logic               ready;
  logic               conflito;

  logic               enable;
  tipo_t              tipo;
  logic               direcao;
  logic [ORI_W-1:0]   orientacao;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;
  logic               jogador;
  logic [IDX_W-1:0]   navio_idx;
  logic               aguardando;
  logic               erro;
  logic               done;

  modport master (
    output start, confirma, x_in, y_in, direcao_in, orientacao_in, ready, conflito,
    input  enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx,
           aguardando, erro, done
  );

  modport slave (
    input  start, confirma, x_in, y_in, direcao_in, orientacao_in, ready, conflito,
    output enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx,
           aguardando, erro, done
  );

endinterface

// File: rtl/sequenciador_posicionamento.sv
// Placement sequencer: walks both players through the fleet, latches entries
// and handshakes with the Validador. Optional SEQ_TIMEOUT_EN aborts stuck validations.
module sequenciador_posicionamento
  import batalha_pkg::*;
#(
  parameter int NUM_NAVIOS     = 5,
  parameter int TIMEOUT_CICLOS = 1023
) (
  input  logic                          clk,
  input  logic                          reset_n,
  sequenciador_posicionamento_if.slave  bus
);

  localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(NUM_NAVIOS - 1);

  estado_t            estado_q, estado_d;
  logic               jogador_q, jogador_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] x1_q, x1_d;
  logic [COORD_W-1:0] y1_q, y1_d;
  logic               dir_q, dir_d;
  logic [ORI_W-1:0]   ori_q, ori_d;
  logic               erro_q, erro_d;
  logic               timeout_w;

`ifdef SEQ_TIMEOUT_EN
  localparam int                CNT_W      = $clog2(TIMEOUT_CICLOS + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMITE = CNT_W'(TIMEOUT_CICLOS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at zero outside VALIDA so every validation attempt starts fresh.
  assign timeout_w = (estado_q == VALIDA) && (cnt_q == CNT_LIMITE);

  always_comb begin
    cnt_d = '0;
    if ((estado_q == VALIDA) && !timeout_w) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign timeout_w      = 1'b0;
  assign unused_timeout = TIMEOUT_CICLOS;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jogador_q <= 1'b0;
      idx_q     <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      dir_q     <= 1'b0;
      ori_q     <= '0;
      erro_q    <= 1'b0;
    end else begin
      jogador_q <= jogador_d;
      idx_q     <= idx_d;
      x1_q      <= x1_d;
      y1_q      <= y1_d;
      dir_q     <= dir_d;
      ori_q     <= ori_d;
      erro_q    <= erro_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    jogador_d = jogador_q;
    idx_d     = idx_q;
    x1_d      = x1_q;
    y1_d      = y1_q;
    dir_d     = dir_q;
    ori_d     = ori_q;
    erro_d    = 1'b0;

    unique case (estado_q)
      OCIOSO, CONCLUIDO: begin
        if (bus.start) begin
          estado_d  = ENTRADA;
          jogador_d = 1'b0;
          idx_d     = '0;
        end
      end

      ENTRADA: begin
        if (bus.confirma) begin
          estado_d = VALIDA;
          x1_d     = bus.x_in;
          y1_d     = bus.y_in;
          dir_d    = bus.direcao_in;
          ori_d    = bus.orientacao_in;
        end
      end

      // A real answer from the Validador takes priority over an expiring timeout.
      VALIDA: begin
        if (bus.ready) begin
          estado_d = bus.conflito ? LIBERA_ERRO : LIBERA_OK;
          erro_d   = bus.conflito;
        end else if (timeout_w) begin
          estado_d = ENTRADA;
          erro_d   = 1'b1;
        end
      end

      LIBERA_ERRO: begin
        if (!bus.ready) begin
          estado_d = ENTRADA;
        end
      end

      LIBERA_OK: begin
        if (!bus.ready) begin
          if (idx_q != ULTIMO) begin
            idx_d    = idx_q + 1'b1;
            estado_d = ENTRADA;
          end else if (!jogador_q) begin
            jogador_d = 1'b1;
            idx_d     = '0;
            estado_d  = ENTRADA;
          end else begin
            estado_d = CONCLUIDO;
          end
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  always_comb begin
    bus.enable     = (estado_q == VALIDA);
    bus.aguardando = (estado_q == ENTRADA);
    bus.done       = (estado_q == CONCLUIDO);
    bus.erro       = erro_q;
    bus.tipo       = tipo_do_navio(idx_q);
    bus.direcao    = dir_q;
    bus.orientacao = ori_q;
    bus.x1         = x1_q;
    bus.y1         = y1_q;
    bus.jogador    = jogador_q;
    bus.navio_idx  = idx_q;
  end

endmodule

// File: tb/tb_sequenciador_posicionamento.sv
// Bench for sequenciador_posicionamento: cycle table for the directed handshake
// cases, then a randomized full game checked against a ship-by-ship fleet model.
module tb_sequenciador_posicionamento;
  import batalha_pkg::*;

  localparam int N = 5;
`ifdef SEQ_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1023;
`endif

  logic clk = 1'b0;
  logic reset_n;

  sequenciador_posicionamento_if bus();

  sequenciador_posicionamento #(.NUM_NAVIOS(N), .TIMEOUT_CICLOS(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int frota_ref [5] = '{0, 1, 2, 3, 4};

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nome, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.confirma = 1'b0; bus.x_in = '0; bus.y_in = '0;
    bus.direcao_in = 1'b0; bus.orientacao_in = '0; bus.ready = 1'b0; bus.conflito = 1'b0;
  endtask

  typedef struct {
    logic st, cf;
    logic [3:0] x, y;
    logic rd, cl;
    logic en, ag, er;
    int   idx;
    logic [3:0] x1, y1;
  } vec_t;

  function automatic vec_t v(input logic st, cf, input logic [3:0] x, y, input logic rd, cl,
                             input logic en, ag, er, input int idx, input logic [3:0] x1, y1);
    vec_t r;
    r.st = st; r.cf = cf; r.x = x; r.y = y; r.rd = rd; r.cl = cl;
    r.en = en; r.ag = ag; r.er = er; r.idx = idx; r.x1 = x1; r.y1 = y1;
    return r;
  endfunction

  vec_t tab [20];

  initial begin
    int m_jog, m_idx, w, n;
    bit m_done, cf;
    logic [3:0] rx, ry;
    logic rdir;
    logic [2:0] rori;

    //         st cf  x   y  rd cl | en ag er idx x1  y1
    tab[0]  = v(1, 0,  0,  0, 0, 0,  0, 1, 0, 0,  0,  0);
    tab[1]  = v(0, 1,  7,  0, 0, 0,  1, 0, 0, 0,  7,  0);
    tab[2]  = v(0, 0,  3,  5, 0, 0,  1, 0, 0, 0,  7,  0);
    tab[3]  = v(0, 0,  3,  5, 0, 0,  1, 0, 0, 0,  7,  0);
    tab[4]  = v(0, 0,  3,  5, 0, 0,  1, 0, 0, 0,  7,  0);
    tab[5]  = v(0, 0,  3,  5, 0, 0,  1, 0, 0, 0,  7,  0);
    tab[6]  = v(0, 0,  3,  0, 1, 0,  0, 0, 0, 0,  7,  0);
    tab[7]  = v(0, 0,  0,  0, 0, 0,  0, 1, 0, 1,  7,  0);
    tab[8]  = v(0, 1,  1,  1, 0, 0,  1, 0, 0, 1,  1,  1);
    tab[9]  = v(0, 0,  0,  0, 1, 1,  0, 0, 1, 1,  1,  1);
    tab[10] = v(0, 0,  0,  0, 1, 0,  0, 0, 0, 1,  1,  1);
    tab[11] = v(0, 0,  0,  0, 0, 0,  0, 1, 0, 1,  1,  1);
    tab[12] = v(0, 1,  2,  2, 0, 0,  1, 0, 0, 1,  2,  2);
    tab[13] = v(0, 1,  9,  9, 1, 0,  0, 0, 0, 1,  2,  2);
    tab[14] = v(0, 0,  0,  0, 1, 0,  0, 0, 0, 1,  2,  2);
    tab[15] = v(0, 0,  0,  0, 1, 0,  0, 0, 0, 1,  2,  2);
    tab[16] = v(0, 0,  0,  0, 0, 0,  0, 1, 0, 2,  2,  2);
    tab[17] = v(1, 0,  0,  0, 0, 0,  0, 1, 0, 2,  2,  2);
    tab[18] = v(0, 1, 15, 15, 0, 0,  1, 0, 0, 2, 15, 15);
    tab[19] = v(1, 0,  0,  0, 0, 0,  1, 0, 0, 2, 15, 15);

    idle_inputs();
    reset_n = 1'b0;
    #12;
    chk("reset enable", bus.enable, 0);
    chk("reset aguardando", bus.aguardando, 0);
    chk("reset done", bus.done, 0);
    chk("reset erro", bus.erro, 0);
    chk("reset tipo", bus.tipo, 0);
    chk("reset navio_idx", bus.navio_idx, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    chk("idle without start", bus.aguardando, 0);

    // Direction follows x[3] and orientation follows y[2:0] so they are checked too.
    for (int i = 0; i < 20; i++) begin
      bus.start = tab[i].st; bus.confirma = tab[i].cf;
      bus.x_in = tab[i].x; bus.y_in = tab[i].y;
      bus.direcao_in = tab[i].x[3]; bus.orientacao_in = tab[i].y[2:0];
      bus.ready = tab[i].rd; bus.conflito = tab[i].cl;
      tick();
      chk($sformatf("row%0d enable", i), bus.enable, tab[i].en);
      chk($sformatf("row%0d aguardando", i), bus.aguardando, tab[i].ag);
      chk($sformatf("row%0d erro", i), bus.erro, tab[i].er);
      chk($sformatf("row%0d navio_idx", i), bus.navio_idx, tab[i].idx);
      chk($sformatf("row%0d tipo", i), bus.tipo, frota_ref[tab[i].idx]);
      chk($sformatf("row%0d x1", i), bus.x1, tab[i].x1);
      chk($sformatf("row%0d y1", i), bus.y1, tab[i].y1);
      chk($sformatf("row%0d direcao", i), bus.direcao, tab[i].x1[3]);
      chk($sformatf("row%0d orientacao", i), bus.orientacao, tab[i].y1[2:0]);
      chk($sformatf("row%0d jogador", i), bus.jogador, 0);
      chk($sformatf("row%0d done", i), bus.done, 0);
    end
    idle_inputs();

    // Asynchronous reset while the Validador is enabled.
    #2 reset_n = 1'b0;
    #1;
    chk("async rst enable", bus.enable, 0);
    chk("async rst x1", bus.x1, 0);
    chk("async rst y1", bus.y1, 0);
    chk("async rst navio_idx", bus.navio_idx, 0);
    chk("async rst tipo", bus.tipo, 0);
    chk("async rst direcao", bus.direcao, 0);
    chk("async rst orientacao", bus.orientacao, 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("after rst needs start", bus.aguardando, 0);
    chk("after rst enable", bus.enable, 0);

    // start and confirma together in OCIOSO: confirma is dropped.
    bus.start = 1'b1; bus.confirma = 1'b1; bus.x_in = 4'd5;
    tick();
    idle_inputs();
    chk("start+confirma aguardando", bus.aguardando, 1);
    chk("start+confirma enable", bus.enable, 0);
    chk("start+confirma x1", bus.x1, 0);

    // Randomized full game against a fleet-level model.
    m_jog = 0; m_idx = 0; m_done = 1'b0;
    for (int t = 0; t < 200 && !m_done; t++) begin
      w = $urandom_range(0, 2);
      repeat (w) tick();
      chk("rnd aguardando", bus.aguardando, 1);
      chk("rnd jogador", bus.jogador, m_jog);
      chk("rnd navio_idx", bus.navio_idx, m_idx);
      chk("rnd tipo", bus.tipo, frota_ref[m_idx]);
      rx = 4'($urandom); ry = 4'($urandom); rdir = 1'($urandom); rori = 3'($urandom);
      bus.confirma = 1'b1; bus.x_in = rx; bus.y_in = ry;
      bus.direcao_in = rdir; bus.orientacao_in = rori;
      tick();
      idle_inputs();
      chk("rnd enable rise", bus.enable, 1);
      chk("rnd x1", bus.x1, rx);
      chk("rnd y1", bus.y1, ry);
      chk("rnd direcao", bus.direcao, rdir);
      chk("rnd orientacao", bus.orientacao, rori);
      w = $urandom_range(0, 3);
      repeat (w) begin
        tick();
        chk("rnd enable held", bus.enable, 1);
      end
      cf = ($urandom_range(0, 3) == 0);
      bus.ready = 1'b1; bus.conflito = cf;
      tick();
      chk("rnd enable fall", bus.enable, 0);
      chk("rnd erro", bus.erro, cf);
      w = $urandom_range(0, 2);
      repeat (w) begin
        tick();
        chk("rnd libera hold", bus.aguardando, 0);
        chk("rnd erro single", bus.erro, 0);
      end
      bus.ready = 1'b0; bus.conflito = 1'b0;
      tick();
      if (!cf) begin
        m_idx++;
        if (m_idx == N) begin
          if (m_jog == 0) begin
            m_jog = 1; m_idx = 0;
          end else begin
            m_done = 1'b1;
          end
        end
      end
      if (m_done) begin
        chk("rnd done", bus.done, 1);
        chk("rnd done enable", bus.enable, 0);
      end else begin
        chk("rnd next aguardando", bus.aguardando, 1);
      end
    end
    chk("game finished", m_done, 1);

    repeat (3) tick();
    chk("done holds", bus.done, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("replay done clear", bus.done, 0);
    chk("replay aguardando", bus.aguardando, 1);
    chk("replay jogador", bus.jogador, 0);
    chk("replay navio_idx", bus.navio_idx, 0);

    bus.confirma = 1'b1; bus.x_in = 4'd4;
    tick();
    idle_inputs();
`ifdef SEQ_TIMEOUT_EN
    n = 0;
    while (bus.enable === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk("timeout enable cycles", n, TMO);
    chk("timeout erro", bus.erro, 1);
    chk("timeout enable", bus.enable, 0);
    chk("timeout aguardando", bus.aguardando, 1);
    chk("timeout navio_idx", bus.navio_idx, 0);
    tick();
    chk("timeout erro single", bus.erro, 0);
`else
    n = 0;
    repeat (40) begin
      tick();
      if (bus.enable === 1'b1) n++;
    end
    chk("no timeout waits", n, 40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sequenciador_posicionamento.md
Name: sequenciador_posicionamento

Overview:
- Upstream placement sequencer for the Validador stage. Walks both players through their fleet in a fixed order and latches each player's coordinate/direction entry on a confirm pulse.
- Drives the Validador enable/placement inputs, waits for its ready, then advances on success or re-requests the same ship on conflict.
- Asserts done when both fleets are placed; the game-phase controller consumes done.

Parameters:
NUM_NAVIOS, 5, ships per player (1..8); fleet order comes from the package table
TIMEOUT_CICLOS, 1023, max cycles to wait for ready before aborting a validation (used only with SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins the placement phase
confirma  in  1  one-cycle pulse; current entry is valid
x_in  in  4  entered column
y_in  in  4  entered row
direcao_in  in  1  entered direction
orientacao_in  in  3  entered orientation
ready  in  1  Validador done
conflito  in  1  Validador result, valid while ready=1
enable  out  1  Validador enable
tipo  out  3  ship type of current ship
direcao  out  1  latched direction
orientacao  out  3  latched orientation
x1  out  4  latched column
y1  out  4  latched row
jogador  out  1  current player (0/1)
navio_idx  out  3  index of current ship in fleet
aguardando  out  1  block waits for confirma
erro  out  1  one-cycle pulse on rejected placement
done  out  1  high while both fleets complete

Behaviour:
- Reset, asynchronous: state OCIOSO. All outputs 0: enable, tipo, direcao, orientacao, x1, y1, jogador, navio_idx, aguardando, erro, done.
- OCIOSO: start -> ENTRADA with jogador=0, navio_idx=0. Other inputs are ignored.
- ENTRADA: aguardando=1; tipo=FROTA[navio_idx]. On confirma, latch x_in/y_in/direcao_in/orientacao_in into x1/y1/direcao/orientacao in the same edge, then go to VALIDA. Placement outputs are stable from then until the next ENTRADA.
- VALIDA: enable=1, starting the cycle after confirma, held high until ready=1 is sampled.
  - ready=1 and conflito=0 -> LIBERA_OK.
  - ready=1 and conflito=1 -> LIBERA_ERRO, with erro pulsed for exactly 1 cycle.
  - confirma is ignored.
- LIBERA_OK / LIBERA_ERRO: enable=0. Remain until ready=0 is sampled, so the Validador sees an enable low phase of at least 1 cycle.
  - LIBERA_ERRO -> ENTRADA with the same navio_idx (retry).
  - LIBERA_OK, navio_idx < NUM_NAVIOS-1 -> navio_idx+1, ENTRADA.
  - LIBERA_OK, last ship and jogador=0 -> jogador=1, navio_idx=0, ENTRADA.
  - LIBERA_OK, last ship and jogador=1 -> CONCLUIDO.
- CONCLUIDO: done=1, enable=0. start -> clear done, restart at jogador=0 (replay).
- Simultaneous events:
  - confirma together with start in OCIOSO: start wins, confirma is dropped.
  - start outside OCIOSO/CONCLUIDO is ignored.
- Entry data is never range-checked here; border checks are the Validador's job.
- Latency: confirma to enable is 1 cycle. ready to next aguardando is at least 2 cycles.
- Reset mid-validation drops enable immediately (asynchronous) and loses progress.

Optional Feature:
- SEQ_TIMEOUT_EN defined:
  - A counter runs in VALIDA, cleared on entry.
  - When it reaches TIMEOUT_CICLOS without ready: pulse erro, drop enable, go to ENTRADA for the same ship.
- Undefined: no counter; VALIDA waits indefinitely.

Decomposition:
- Package batalha_pkg:
  - state enum
  - tipo codes
  - FROTA constant array (porta-avioes=0, encouracado=1, cruzador=2, submarino=3, destroier=4)
  - coordinate width constant 4
- No sub-module; the optional timeout counter is inline.

Test Plan:
1. Reset, start, confirma (x=7, y=0, dir=0, ori=0), ready with conflito=0 after 5 cycles. Required: enable rises 1 cycle after confirma; x1=7, y1=0, tipo=0; enable falls the cycle after ready; navio_idx=1, aguardando=1.
2. confirma (x=1, y=1), ready with conflito=1. Required: erro pulse of exactly 1 cycle; navio_idx unchanged; retry with (2,2) and conflito=0 advances to navio_idx+1.
3. Place 5 ships for jogador 0 successfully. Required: jogador flips to 1, navio_idx=0, tipo=0; after 5 more, done=1, enable=0.
4. Hold ready high for 3 cycles after acceptance. Required: block stays in LIBERA until ready=0; no double advance.
5. Assert reset_n low while enable=1. Required: all outputs 0 asynchronously; start needed to resume.
6. SEQ_TIMEOUT_EN with TIMEOUT_CICLOS=16, ready never asserted. Required: erro after 16 cycles in VALIDA, enable=0, aguardando=1, same navio_idx.
